// File: rtl/trng_arb_pkg.sv
// trng_arb_pkg: state encoding and EHR size defaults shared by the TRNG EHR arbiter.
package trng_arb_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_EHR = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_PRESENT  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // EHR depth in 32-bit words for the two supported entropy builds
    localparam int unsigned EHR_WORDS_128 = 4;
    localparam int unsigned EHR_WORDS_192 = 6;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        WAIT_EHR = ST_WAIT_EHR,
        LOAD     = ST_LOAD,
        PRESENT  = ST_PRESENT,
        DONE     = ST_DONE
    } arb_state_t;

endpackage

// File: rtl/trng_arb_wait_cnt.sv
// trng_arb_wait_cnt: saturating wait-for-entropy counter.
// Only compiled when TRNG_EHR_ARB_TIMEOUT_EN is defined; the arbiter has no
// counter at all otherwise.
`ifdef TRNG_EHR_ARB_TIMEOUT_EN
module trng_arb_wait_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Saturate at all-ones so a very long wait can never wrap back under the limit
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    // Limit of zero disables the timeout; hit flags the edge where the count reaches it
    assign hit = en && (limit != '0) && (cnt_inc >= limit);

    // Count wait cycles; cleared when a new wait begins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_inc;
        end
    end

endmodule
`endif

// File: rtl/trng_ehr_arbiter.sv
// trng_ehr_arbiter: shares the TRNG entropy holding register between the PRNG
// reseed engine and CPU reads, then streams the EHR words to the PRNG.
// Optional wait-for-entropy timeout built when TRNG_EHR_ARB_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | EHR owned by the CPU side; waiting for an armed PRNG request
// WAIT_EHR | PRNG owns the EHR, waiting for trng_valid (optional timeout)
// LOAD     | capture ehr_rdata for the current word index
// PRESENT  | word shown to the PRNG, waiting for prng_word_ack
// DONE     | transfer complete, prng_done pulses, ownership released
module trng_ehr_arbiter
    import trng_arb_pkg::*;
#(
    parameter int unsigned EHR_WORDS  = EHR_WORDS_192,
    parameter int unsigned WORD_IDX_W = 3,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic                  rng_clk,
    input  logic                  rst_n,
    input  logic                  rng_debug_enable,
    input  logic                  trng_valid,
    input  logic                  cpu_in_mid_rd_of_ehr_not_in_debug_mode,
    input  logic [31:0]           ehr_rdata,
    input  logic                  prng_req,
    input  logic                  prng_word_ack,
    input  logic [TIMEOUT_W-1:0]  timeout_val,
    output logic                  prng_busy,
    output logic                  prng_trng_ehr_rd,
    output logic [WORD_IDX_W-1:0] ehr_word_idx,
    output logic [31:0]           prng_word,
    output logic                  prng_word_vld,
    output logic                  prng_done,
    output logic                  prng_timeout
);

    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(EHR_WORDS - 1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic                  armed;
    logic [WORD_IDX_W-1:0] idx;
    logic [31:0]           word;
    logic                  vld;
    logic                  done_q;
    logic                  abort_req;
    logic                  grant;
    logic                  last_ack;
    logic                  wait_hit;
    logic                  timeout_fire;

    // Request withdrawn or debug mode entered: the transfer is abandoned
    assign abort_req = !prng_req || rng_debug_enable;

`ifdef TRNG_EHR_ARB_TIMEOUT_EN
    logic timeout_q;

    trng_arb_wait_cnt #(
        .CNT_W (TIMEOUT_W)
    ) u_wait_cnt (
        .clk   (rng_clk),
        .rst_n (rst_n),
        .clr   (grant),
        .en    (state == WAIT_EHR),
        .limit (timeout_val),
        .hit   (wait_hit)
    );

    // Sticky timeout flag; only a new grant or reset clears it
    always_ff @(posedge rng_clk) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (grant) begin
            timeout_q <= 1'b0;
        end else if (timeout_fire) begin
            timeout_q <= 1'b1;
        end
    end

    assign prng_timeout = timeout_q;
`else
    logic unused_timeout_val;

    assign unused_timeout_val = ^timeout_val;
    assign wait_hit           = 1'b0;
    assign prng_timeout       = 1'b0;
`endif

    // Next-state decode; the CPU wins any collision because grant requires its flag low
    always_comb begin
        state_nxt    = state;
        grant        = 1'b0;
        last_ack     = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                if (prng_req && !rng_debug_enable &&
                    !cpu_in_mid_rd_of_ehr_not_in_debug_mode && armed) begin
                    grant     = 1'b1;
                    state_nxt = WAIT_EHR;
                end
            end
            WAIT_EHR: begin
                if (abort_req) begin
                    state_nxt = IDLE;
                end else if (trng_valid) begin
                    state_nxt = LOAD;
                end else if (wait_hit) begin
                    timeout_fire = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            LOAD: begin
                state_nxt = abort_req ? IDLE : PRESENT;
            end
            PRESENT: begin
                if (abort_req) begin
                    state_nxt = IDLE;
                end else if (prng_word_ack) begin
                    if (idx == LAST_IDX) begin
                        last_ack  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge rng_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word index, presented word, done pulse and re-arm tracking
    // armed comes out of reset set, so a request already pending after reset is served
    always_ff @(posedge rng_clk) begin
        if (!rst_n) begin
            armed  <= 1'b1;
            idx    <= '0;
            word   <= '0;
            vld    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_ack || timeout_fire;
            if (!prng_req) begin
                armed <= 1'b1;
            end else if (grant) begin
                armed <= 1'b0;
            end
            if (state_nxt == IDLE) begin
                idx <= '0;
                vld <= 1'b0;
            end else if (state == LOAD) begin
                word <= ehr_rdata;
                vld  <= 1'b1;
            end else if (state == PRESENT && prng_word_ack) begin
                vld <= 1'b0;
                idx <= last_ack ? '0 : idx + 1'b1;
            end
        end
    end

    assign prng_busy        = (state != IDLE);
    assign prng_trng_ehr_rd = last_ack && rst_n;
    assign ehr_word_idx     = idx;
    assign prng_word        = word;
    assign prng_word_vld    = vld;
    assign prng_done        = done_q;

endmodule

// File: tb/tb_trng_ehr_arbiter.sv
// tb_trng_ehr_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the EHR arbiter.
module tb_trng_ehr_arbiter;

    localparam int N  = 6;
    localparam int IW = 3;
    localparam int TW = 16;
`ifdef TRNG_EHR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          rng_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rng_debug_enable = 1'b0;
    logic          trng_valid = 1'b0;
    logic          cpu_mid = 1'b0;
    logic [31:0]   ehr_rdata;
    logic          prng_req = 1'b0;
    logic          prng_word_ack = 1'b0;
    logic [TW-1:0] timeout_val = '0;
    logic          prng_busy;
    logic          prng_trng_ehr_rd;
    logic [IW-1:0] ehr_word_idx;
    logic [31:0]   prng_word;
    logic          prng_word_vld;
    logic          prng_done;
    logic          prng_timeout;

    logic [31:0] ehr_mem [8];

    assign ehr_rdata = ehr_mem[ehr_word_idx];

    always #5 rng_clk = ~rng_clk;

    trng_ehr_arbiter #(
        .EHR_WORDS  (N),
        .WORD_IDX_W (IW),
        .TIMEOUT_W  (TW)
    ) dut (
        .rng_clk                                (rng_clk),
        .rst_n                                  (rst_n),
        .rng_debug_enable                       (rng_debug_enable),
        .trng_valid                             (trng_valid),
        .cpu_in_mid_rd_of_ehr_not_in_debug_mode (cpu_mid),
        .ehr_rdata                              (ehr_rdata),
        .prng_req                               (prng_req),
        .prng_word_ack                          (prng_word_ack),
        .timeout_val                            (timeout_val),
        .prng_busy                              (prng_busy),
        .prng_trng_ehr_rd                       (prng_trng_ehr_rd),
        .ehr_word_idx                           (ehr_word_idx),
        .prng_word                              (prng_word),
        .prng_word_vld                          (prng_word_vld),
        .prng_done                              (prng_done),
        .prng_timeout                           (prng_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Model of the arbiter: ownership, where we are in the word stream, pulses
    bit          m_busy, m_wait, m_shown, m_closing, m_done, m_timeout, m_armed;
    int          m_idx, m_wcnt;
    logic [31:0] m_word;

    // Observations gathered while stepping
    int          busy_cnt, rd_cnt, done_cnt;
    bit          last_busy;
    logic [31:0] rx_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_wait = 0; m_shown = 0; m_closing = 0; m_done = 0;
        m_timeout = 0; m_armed = 1; m_idx = 0; m_wcnt = 0; m_word = '0;
    endtask

    task automatic model_update(input bit r, input bit req, input bit dbg, input bit cpu,
                                input bit valid, input bit ack, input logic [TW-1:0] tval);
        int nxt;
        if (!r) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (!m_busy) begin
            if (req && !dbg && !cpu && m_armed) begin
                m_busy = 1; m_wait = 1; m_wcnt = 0; m_timeout = 0; m_armed = 0;
            end
        end else if (m_closing) begin
            m_busy = 0; m_closing = 0;
        end else if (!req || dbg) begin
            m_busy = 0; m_wait = 0; m_shown = 0; m_idx = 0;
        end else if (m_wait) begin
            if (valid) begin
                m_wait = 0; m_idx = 0;
            end else begin
                nxt = (m_wcnt >= (1 << TW) - 1) ? m_wcnt : m_wcnt + 1;
                m_wcnt = nxt;
                if (TO_EN && tval != 0 && nxt >= int'(tval)) begin
                    m_busy = 0; m_wait = 0; m_timeout = 1; m_done = 1;
                end
            end
        end else if (!m_shown) begin
            m_word = ehr_mem[m_idx];
            m_shown = 1;
        end else if (ack) begin
            m_shown = 0;
            if (m_idx == N - 1) begin
                m_closing = 1; m_done = 1; m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (!req) m_armed = 1;
    endtask

    // One clock cycle: drive inputs at negedge, compare against the model, advance the model
    task automatic step(input bit r, input bit req, input bit dbg, input bit cpu,
                        input bit valid, input bit ack, input logic [TW-1:0] tval,
                        input bit refresh);
        bit exp_rd;
        @(negedge rng_clk);
        if (refresh && !m_busy) begin
            for (int i = 0; i < 8; i++) ehr_mem[i] = $urandom;
        end
        rst_n = r; prng_req = req; rng_debug_enable = dbg; cpu_mid = cpu;
        trng_valid = valid; prng_word_ack = ack; timeout_val = tval;
        #1;
        exp_rd = r && m_shown && ack && req && !dbg && (m_idx == N - 1);
        check_eq("busy", prng_busy, m_busy);
        check_eq("word_vld", prng_word_vld, m_shown);
        check_eq("word_idx", ehr_word_idx, m_idx);
        check_eq("done", prng_done, m_done);
        check_eq("timeout", prng_timeout, m_timeout);
        check_eq("ehr_rd", prng_trng_ehr_rd, exp_rd);
        if (m_shown) check_eq("word", prng_word, m_word);
        last_busy = prng_busy;
        if (prng_busy) busy_cnt++;
        if (prng_trng_ehr_rd) rd_cnt++;
        if (prng_done) done_cnt++;
        if (prng_word_vld && ack) rx_q.push_back(prng_word);
        model_update(r, req, dbg, cpu, valid, ack, tval);
    endtask

    task automatic clear_obs();
        busy_cnt = 0; rd_cnt = 0; done_cnt = 0;
        rx_q.delete();
    endtask

    initial begin
        bit          req_r, dbg_r, rst_r, cpu_r, val_r, ack_r;
        logic [TW-1:0] tv;
        bit          found;

        for (int i = 0; i < 8; i++) ehr_mem[i] = 32'h0;
        repeat (2) @(posedge rng_clk);
        model_reset();
        clear_obs();

        // Reset state
        #2;
        check_eq("rst_busy", prng_busy, 0);
        check_eq("rst_vld", prng_word_vld, 0);
        check_eq("rst_idx", ehr_word_idx, 0);
        check_eq("rst_done", prng_done, 0);
        check_eq("rst_rd", prng_trng_ehr_rd, 0);
        check_eq("rst_timeout", prng_timeout, 0);

        // Full six-word reseed with ack held high
        for (int i = 0; i < N; i++) ehr_mem[i] = 32'h1111_1111 * (i + 1);
        step(1, 0, 0, 0, 1, 1, 0, 0);
        clear_obs();
        repeat (16) step(1, 1, 0, 0, 1, 1, 0, 0);
        check_eq("t1_busy_cycles", busy_cnt, 14);
        check_eq("t1_rd_pulses", rd_cnt, 1);
        check_eq("t1_done_pulses", done_cnt, 1);
        check_eq("t1_word_count", rx_q.size(), N);
        for (int i = 0; i < N && i < rx_q.size(); i++)
            check_eq("t1_word_order", rx_q[i], 32'h1111_1111 * (i + 1));
        step(1, 0, 0, 0, 1, 1, 0, 0);

        // CPU mid-read blocks the grant until it drops
        clear_obs();
        repeat (5) step(1, 1, 0, 1, 0, 0, 0, 0);
        check_eq("t2_no_grant", busy_cnt, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check_eq("t2_grant", last_busy, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Request dropped after word 2 is acked
        clear_obs();
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            step(1, 1, 0, 0, 1, 1, 0, 0);
            found = (rx_q.size() >= 3);
        end
        check_eq("t3_three_words", rx_q.size(), 3);
        step(1, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0, 0);
        check_eq("t3_busy_after_abort", last_busy, 0);
        check_eq("t3_no_rd", rd_cnt, 0);

        // Wait for entropy with timeout_val = 8
        clear_obs();
        repeat (12) step(1, 1, 0, 0, 0, 0, 8, 0);
        check_eq("t4_timeout", prng_timeout, TO_EN);
        check_eq("t4_done_pulses", done_cnt, TO_EN ? 1 : 0);
        check_eq("t4_busy_cycles", busy_cnt, TO_EN ? 8 : 11);
        step(1, 0, 0, 0, 0, 0, 8, 0);

        // Reset while word 3 is presented
        clear_obs();
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            step(1, 1, 0, 0, 1, m_idx < 3, 0, 0);
            found = m_shown && (m_idx == 3);
        end
        check_eq("t5_reached_word3", found, 1);
        step(0, 1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t5_busy", prng_busy, 0);
        check_eq("t5_vld", prng_word_vld, 0);
        check_eq("t5_idx", ehr_word_idx, 0);
        check_eq("t5_word", prng_word, 0);
        check_eq("t5_no_rd", rd_cnt, 0);

        // Debug mode blocks the grant; clearing it grants on the next edge
        clear_obs();
        repeat (10) step(1, 1, 1, 0, 0, 0, 0, 0);
        check_eq("t6_no_grant", busy_cnt, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check_eq("t6_grant", last_busy, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        req_r = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(11) == 0) req_r = !req_r;
            dbg_r = ($urandom_range(39) == 0);
            rst_r = ($urandom_range(149) != 0);
            cpu_r = ($urandom_range(7) == 0);
            val_r = ($urandom_range(3) != 0);
            ack_r = ($urandom_range(1) == 0);
            tv    = TW'($urandom_range(12));
            step(rst_r, req_r, dbg_r, cpu_r, val_r, ack_r, tv, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
